key_sw_reader: RTL and testbench
================================

// Module: key_sw_reader
// PURPOSE
//  Input-side companion to the LED pattern driver: reads raw push-keys and slide switches.
//  Synchronises and debounces each key, then emits a one-cycle press pulse and a one-cycle
//  long-press pulse per key. On a key 0 press it captures the switch bank into a
//  valid/ready output register, from which the pattern logic takes a new pattern/mode word.
// PARAMETERS
//  N_KEYS    4        number of push-keys (>=1); key 0 is the switch-capture key
//  SW_W      8        switch bank width
//  DB_CNT    500000   stable cycles required to accept a level change (10 ms at 50 MHz); >=2
//  LONG_CNT  50000000 cycles in PRESSED, counted after key_press, before key_long fires (1 s); >DB_CNT
//  CNT_W     26       counter width; must hold max(DB_CNT, LONG_CNT)
// PORTS
//  clk        in   1       system clock, single clock domain
//  rst        in   1       synchronous reset, active-high
//  key_in     in   N_KEYS  raw keys, asynchronous, 1 = pressed
//  sw_in      in   SW_W    raw switches, asynchronous
//  key_level  out  N_KEYS  debounced key level
//  key_press  out  N_KEYS  1-cycle pulse on accepted press
//  key_long   out  N_KEYS  1-cycle pulse, at most once per press
//  sw_data    out  SW_W    captured switch word
//  sw_valid   out  1       sw_data holds an unconsumed word
//  sw_ready   in   1       consumer accepts sw_data when sw_valid & sw_ready
//  sw_overrun out  1       1-cycle pulse: capture dropped because a word was still pending
// BEHAVIOUR
//  - Reset (rst=1 at posedge clk): all outputs 0. Synchronisers 0. Every key FSM in IDLE.
//    Counters 0. rst mid-debounce or mid-hold aborts without emitting any pulse.
//  - Sync: 2-flop synchroniser on every key_in and sw_in bit. Only synchronised values are used.
//  - Per-key FSM, with s = synchronised key and a shared-width counter cnt:
//    IDLE:    s=1 -> PRESS_WAIT, cnt=1.
//    PRESS_WAIT: s=0 -> IDLE. Else if cnt==DB_CNT-1 -> PRESSED, key_press=1 next cycle,
//             key_level=1, cnt=0. Else cnt++.
//    PRESSED: s=0 -> RELEASE_WAIT, cnt=1. Else cnt saturates at LONG_CNT; key_long pulses
//             exactly on the cycle cnt reaches LONG_CNT.
//    RELEASE_WAIT: s=1 -> PRESSED, cnt=LONG_CNT, so no second key_long. Else if cnt==DB_CNT-1
//             -> IDLE, key_level=0. Else cnt++.
//  - Latency: key_press is asserted DB_CNT cycles after s first goes high, and 2 cycles
//    after key_in (synchroniser). A glitch of fewer than DB_CNT cycles produces no pulse.
//  - Capture, on key_press[0]: sw_data <= synchronised sw_in and sw_valid <= 1.
//    Priority in the same cycle:
//      capture & (!sw_valid | sw_ready): load, sw_valid stays 1, no overrun
//      capture & sw_valid & !sw_ready:   keep old word, sw_overrun=1
//      no capture & sw_valid & sw_ready: sw_valid <= 0; sw_data holds its last value
//  - sw_data is stable while sw_valid=1 and sw_ready=0.
//  - Keys are independent. Simultaneous presses on several keys give simultaneous pulses.
// STRUCTURE
//  - Shared header led_io_defs.vh: FSM state encodings (IDLE=2'd0, PRESS_WAIT=2'd1,
//    PRESSED=2'd2, RELEASE_WAIT=2'd3) plus default DB_CNT/LONG_CNT for 50 MHz.
//  - Sub-module key_debounce_cell (params DB_CNT, LONG_CNT, CNT_W; ports clk, rst,
//    key_raw, level, press, long_press), instantiated N_KEYS times in a generate loop.
//  - Top holds the switch synchroniser, the capture register, the valid/ready logic and overrun.
// TESTING  (sim params: DB_CNT=4, LONG_CNT=10, N_KEYS=4, SW_W=8)
//  1 rst=1 with key_in=4'hF held; release rst -> all outputs 0 during reset; key_press[3:0]
//    pulse together 2+4 cycles after rst falls.
//  2 key_in[1] high for 3 cycles, then low -> no key_press[1]. High for 6 cycles -> one
//    key_press[1] pulse, key_level[1]=1.
//  3 key_in[2] held 20 cycles -> key_press[2] once, key_long[2] once exactly 10 cycles later.
//    Release bounce 1-0-1-0 -> no second press/long; key_level[2] drops after a stable 4 cycles low.
//  4 sw_in=8'hA5, press key 0, sw_ready=0 -> sw_data=8'hA5, sw_valid=1. sw_in=8'h3C, press
//    again -> sw_overrun pulse, sw_data stays 8'hA5. sw_ready=1 -> sw_valid=0 next cycle.
//  5 sw_valid=1 and sw_ready=1 in the same cycle as key_press[0] with sw_in=8'h81 ->
//    sw_data=8'h81, sw_valid stays 1, no overrun.
//  6 rst asserted while key 3 is in PRESSED with cnt=7 -> no key_long[3]; key_level[3]=0
//    the following cycle.

Source files
------------

// File: rtl/key_sw_reader_pkg.sv
// Shared definitions for the key/switch reader: per-key FSM encoding and default timing for a
// 50 MHz system clock.
package key_sw_reader_pkg;

  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } key_state_e;

  // 10 ms debounce and 1 s long-press at 50 MHz
  localparam int unsigned DefDbCnt   = 500000;
  localparam int unsigned DefLongCnt = 50000000;
  localparam int unsigned DefCntW    = 26;

endpackage

// File: rtl/key_debounce_cell.sv
// One push-key: 2-flop synchroniser, debounce FSM, registered level, press and long-press pulses.
module key_debounce_cell
  import key_sw_reader_pkg::*;
#(
  parameter int unsigned DB_CNT   = DefDbCnt,
  parameter int unsigned LONG_CNT = DefLongCnt,
  parameter int unsigned CNT_W    = DefCntW
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_raw_i,
  output logic level_o,
  output logic press_o,
  output logic long_press_o
);

  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DB_CNT - 1);
  localparam logic [CNT_W-1:0] LongMax  = CNT_W'(LONG_CNT);
  localparam logic [CNT_W-1:0] LongPrev = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic [1:0]       sync_q;
  logic             key_s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             long_q, long_d;

  assign key_s = sync_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b00;
      state_q <= StIdle;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_s) begin
          state_d = StPressWait;
          cnt_d   = CntOne;
        end
      end
      StPressWait: begin
        if (!key_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d = StPressed;
          press_d = 1'b1;
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StPressed: begin
        if (!key_s) begin
          state_d = StReleaseWait;
          cnt_d   = CntOne;
        end else if (cnt_q != LongMax) begin
          // Saturating hold counter: the pulse fires only on the step into LongMax.
          cnt_d  = cnt_q + CntOne;
          long_d = (cnt_q == LongPrev);
        end
      end
      StReleaseWait: begin
        if (key_s) begin
          // Bounce back to pressed with the hold counter spent, so no second long pulse.
          state_d = StPressed;
          cnt_d   = LongMax;
        end else if (cnt_q == DbLast) begin
          state_d = StIdle;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign long_press_o = long_q;

endmodule

// File: rtl/key_sw_reader.sv
// Reads push-keys and slide switches: per-key debounce cells plus a valid/ready switch-capture
// register loaded on each accepted key 0 press.
module key_sw_reader
  import key_sw_reader_pkg::*;
#(
  parameter int unsigned N_KEYS   = 4,
  parameter int unsigned SW_W     = 8,
  parameter int unsigned DB_CNT   = DefDbCnt,
  parameter int unsigned LONG_CNT = DefLongCnt,
  parameter int unsigned CNT_W    = DefCntW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_KEYS-1:0] key_i,
  input  logic [SW_W-1:0]   sw_i,
  output logic [N_KEYS-1:0] key_level_o,
  output logic [N_KEYS-1:0] key_press_o,
  output logic [N_KEYS-1:0] key_long_o,
  output logic [SW_W-1:0]   sw_data_o,
  output logic              sw_valid_o,
  input  logic              sw_ready_i,
  output logic              sw_overrun_o
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DB_CNT  (DB_CNT),
      .LONG_CNT(LONG_CNT),
      .CNT_W   (CNT_W)
    ) u_cell (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .key_raw_i   (key_i[i]),
      .level_o     (key_level_o[i]),
      .press_o     (key_press_o[i]),
      .long_press_o(key_long_o[i])
    );
  end

  logic [SW_W-1:0] sw_meta_q, sw_sync_q;
  logic [SW_W-1:0] data_q, data_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            capture;

  assign capture = key_press_o[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (capture) begin
      // A pending word being consumed this cycle frees the slot for the new capture.
      if (!valid_q || sw_ready_i) begin
        data_d  = sw_sync_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && sw_ready_i) begin
      valid_d = 1'b0;
    end
  end

  assign sw_data_o    = data_q;
  assign sw_valid_o   = valid_q;
  assign sw_overrun_o = overrun_q;

endmodule

// File: tb/tb_key_sw_reader.sv
// Scoreboard bench for key_sw_reader with short debounce/long-press timing.
module tb_key_sw_reader;

  localparam int unsigned NK = 4;
  localparam int unsigned SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_i;
  logic [SW-1:0] sw_i;
  logic          sw_ready_i;
  logic [NK-1:0] key_level_o;
  logic [NK-1:0] key_press_o;
  logic [NK-1:0] key_long_o;
  logic [SW-1:0] sw_data_o;
  logic          sw_valid_o;
  logic          sw_overrun_o;

  key_sw_reader #(
    .N_KEYS  (NK),
    .SW_W    (SW),
    .DB_CNT  (4),
    .LONG_CNT(10),
    .CNT_W   (26)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_i       (key_i),
    .sw_i        (sw_i),
    .key_level_o (key_level_o),
    .key_press_o (key_press_o),
    .key_long_o  (key_long_o),
    .sw_data_o   (sw_data_o),
    .sw_valid_o  (sw_valid_o),
    .sw_ready_i  (sw_ready_i),
    .sw_overrun_o(sw_overrun_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [NK-1:0] press;
    logic [NK-1:0] lng;
    logic          ovr;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int c, input logic [NK-1:0] p, input logic [NK-1:0] l,
                           input logic o);
    ev_t e;
    e.cyc   = c;
    e.press = p;
    e.lng   = l;
    e.ovr   = o;
    exp_q.push_back(e);
  endtask

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: any pulse output must match the next expected event, including its cycle.
  always @(negedge clk) begin
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event: no pulse observed, expected press=%h long=%h ovr=%b at cycle %0d",
               e.press, e.lng, e.ovr, e.cyc);
    end
    if (key_press_o != '0 || key_long_o != '0 || sw_overrun_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got press=%h long=%h ovr=%b at cycle %0d, expected none",
                 key_press_o, key_long_o, sw_overrun_o, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_press", 32'(key_press_o), 32'(e.press));
        check("event_long", 32'(key_long_o), 32'(e.lng));
        check("event_overrun", 32'(sw_overrun_o), 32'(e.ovr));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: run exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int f;
    rst        = 1'b1;
    key_i      = 4'hF;
    sw_i       = 8'h00;
    sw_ready_i = 1'b0;

    // 1: reset with all keys held, then simultaneous presses
    go(3);
    check("rst_level", 32'(key_level_o), 0);
    check("rst_press", 32'(key_press_o), 0);
    check("rst_long", 32'(key_long_o), 0);
    check("rst_valid", 32'(sw_valid_o), 0);
    check("rst_data", 32'(sw_data_o), 0);
    check("rst_overrun", 32'(sw_overrun_o), 0);
    rst = 1'b0;
    e   = cyc;
    expect_ev(e + 6, 4'hF, 4'h0, 1'b0);
    go(6);
    check("t1_level", 32'(key_level_o), 32'hF);
    go(1);
    check("t1_valid", 32'(sw_valid_o), 1);
    check("t1_data", 32'(sw_data_o), 32'h00);
    sw_ready_i = 1'b1;
    go(1);
    sw_ready_i = 1'b0;
    check("t1_drain", 32'(sw_valid_o), 0);
    key_i = 4'h0;
    go(12);
    check("t1_release", 32'(key_level_o), 0);

    // 2: short glitch rejected, then a clean press
    key_i[1] = 1'b1;
    go(3);
    key_i[1] = 1'b0;
    go(12);
    check("t2_glitch_level", 32'(key_level_o), 0);
    key_i[1] = 1'b1;
    e = cyc;
    expect_ev(e + 6, 4'b0010, 4'h0, 1'b0);
    go(6);
    key_i[1] = 1'b0;
    check("t2_level", 32'(key_level_o), 32'h2);
    go(5);
    check("t2_level_hold", 32'(key_level_o), 32'h2);
    go(1);
    check("t2_level_drop", 32'(key_level_o), 0);
    go(4);

    // 3: long press, then bouncing release
    key_i[2] = 1'b1;
    e = cyc;
    expect_ev(e + 6, 4'b0100, 4'h0, 1'b0);
    expect_ev(e + 16, 4'h0, 4'b0100, 1'b0);
    go(20);
    key_i[2] = 1'b0;
    go(1);
    key_i[2] = 1'b1;
    go(1);
    key_i[2] = 1'b0;
    go(1);
    key_i[2] = 1'b1;
    go(1);
    key_i[2] = 1'b0;
    f = cyc;
    go(5);
    check("t3_level_hold", 32'(key_level_o), 32'h4);
    go(1);
    check("t3_level_drop", 32'(key_level_o), 0);
    go(4);

    // 4: capture, overrun while pending, then drain
    sw_i     = 8'hA5;
    key_i[0] = 1'b1;
    e = cyc;
    expect_ev(e + 6, 4'b0001, 4'h0, 1'b0);
    go(6);
    key_i[0] = 1'b0;
    go(1);
    check("t4_valid", 32'(sw_valid_o), 1);
    check("t4_data", 32'(sw_data_o), 32'hA5);
    go(8);
    sw_i     = 8'h3C;
    key_i[0] = 1'b1;
    e = cyc;
    expect_ev(e + 6, 4'b0001, 4'h0, 1'b0);
    expect_ev(e + 7, 4'h0, 4'h0, 1'b1);
    go(6);
    key_i[0] = 1'b0;
    go(1);
    check("t4_ovr_valid", 32'(sw_valid_o), 1);
    check("t4_ovr_data", 32'(sw_data_o), 32'hA5);
    go(8);
    sw_ready_i = 1'b1;
    go(1);
    sw_ready_i = 1'b0;
    check("t4_drain_valid", 32'(sw_valid_o), 0);
    check("t4_drain_data", 32'(sw_data_o), 32'hA5);

    // 5: capture in the same cycle the pending word is consumed
    sw_i     = 8'h11;
    key_i[0] = 1'b1;
    e = cyc;
    expect_ev(e + 6, 4'b0001, 4'h0, 1'b0);
    go(6);
    key_i[0] = 1'b0;
    go(1);
    check("t5_pre_data", 32'(sw_data_o), 32'h11);
    go(8);
    sw_i     = 8'h81;
    key_i[0] = 1'b1;
    e = cyc;
    expect_ev(e + 6, 4'b0001, 4'h0, 1'b0);
    go(6);
    key_i[0]   = 1'b0;
    sw_ready_i = 1'b1;
    go(1);
    sw_ready_i = 1'b0;
    check("t5_valid", 32'(sw_valid_o), 1);
    check("t5_data", 32'(sw_data_o), 32'h81);
    go(8);

    // 6: reset during a hold aborts without a long pulse
    key_i[3] = 1'b1;
    e = cyc;
    expect_ev(e + 6, 4'b1000, 4'h0, 1'b0);
    go(13);
    rst      = 1'b1;
    key_i[3] = 1'b0;
    go(1);
    check("t6_level", 32'(key_level_o), 0);
    check("t6_long", 32'(key_long_o), 0);
    check("t6_valid", 32'(sw_valid_o), 0);
    go(1);
    rst = 1'b0;
    go(20);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
